// File: rtl/com_pixel_feeder_if.sv
// Signal bundle between the camera pipeline, center_of_mass and com_pixel_feeder.
// The slave modport is the feeder's view; master is the environment's view.
interface com_pixel_feeder_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [7:0]  channel_in;
  logic        data_valid_in;
  logic [7:0]  lower_bound_in;
  logic [7:0]  upper_bound_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        tabulate_out;
  logic [10:0] com_x_in;
  logic [9:0]  com_y_in;
  logic        com_valid_in;
  logic        mask_out;
  logic [10:0] centroid_x_out;
  logic [9:0]  centroid_y_out;
  logic        centroid_valid_out;
  logic [7:0]  frames_dropped_out;

  modport slave (
    input  hcount_in, vcount_in, channel_in, data_valid_in,
           lower_bound_in, upper_bound_in, com_x_in, com_y_in, com_valid_in,
    output x_out, y_out, valid_out, tabulate_out, mask_out,
           centroid_x_out, centroid_y_out, centroid_valid_out, frames_dropped_out
  );

  modport master (
    output hcount_in, vcount_in, channel_in, data_valid_in,
           lower_bound_in, upper_bound_in, com_x_in, com_y_in, com_valid_in,
    input  x_out, y_out, valid_out, tabulate_out, mask_out,
           centroid_x_out, centroid_y_out, centroid_valid_out, frames_dropped_out
  );
endinterface

// File: rtl/com_pixel_feeder.sv
// Thresholds the camera stream, feeds in-mask samples and a per-frame tabulate
// pulse to center_of_mass, and holds the returned centroid for overlay logic.
module com_pixel_feeder #(
  parameter int H_ACTIVE       = 1024,
  parameter int V_ACTIVE       = 768,
  parameter int MIN_PIXELS     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             clk_in,
  input logic             rst_in,
  com_pixel_feeder_if.slave pf
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, TABULATE, WAIT_RESULT} state_t;

  state_t        state_q, state_d;
  logic [20:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [10:0]   x_q, x_d, cx_q, cx_d;
  logic [9:0]    y_q, y_d, cy_q, cy_d;
  logic          valid_q, valid_d, tab_q, tab_d, mask_q, mask_d, cv_q, cv_d;
  logic [7:0]    drop_q, drop_d;
  logic          in_mask, frame_start, last_px, emit, drop_inc;

  always_comb begin
    in_mask     = pf.data_valid_in && (pf.lower_bound_in <= pf.channel_in) &&
                  (pf.channel_in <= pf.upper_bound_in);
    frame_start = pf.data_valid_in && (pf.hcount_in == '0) && (pf.vcount_in == '0);
    last_px     = pf.data_valid_in && (pf.hcount_in == 11'(H_ACTIVE - 1)) &&
                  (pf.vcount_in == 10'(V_ACTIVE - 1));
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    x_d      = x_q;
    y_d      = y_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cv_d     = cv_q;
    drop_d   = drop_q;
    valid_d  = 1'b0;
    tab_d    = 1'b0;
    mask_d   = in_mask;
    emit     = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      IDLE: if (frame_start) begin
        state_d = STREAM;
        count_d = '0;
        emit    = 1'b1;
      end
      STREAM: begin
        emit = 1'b1;
        // A new frame start here means the previous frame was truncated.
        if (frame_start) begin
          count_d  = '0;
          drop_inc = 1'b1;
        end else if (last_px) begin
          state_d = FLUSH;
        end
      end
      // FLUSH leaves one quiet cycle between the last sample and tabulate.
      FLUSH: begin
        drop_inc = frame_start;
        state_d  = TABULATE;
      end
      TABULATE: begin
        tab_d    = 1'b1;
        drop_inc = frame_start;
        if (count_q == '0) begin
          state_d = IDLE;
          cv_d    = 1'b0;
        end else begin
          state_d = WAIT_RESULT;
          timer_d = '0;
        end
      end
      WAIT_RESULT: begin
        drop_inc = frame_start;
        if (pf.com_valid_in) begin
          cx_d    = pf.com_x_in;
          cy_d    = pf.com_y_in;
          cv_d    = (count_q >= 21'(MIN_PIXELS));
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          cv_d     = 1'b0;
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit && in_mask) begin
      valid_d = 1'b1;
      x_d     = pf.hcount_in;
      y_d     = pf.vcount_in;
      if (count_d != '1) count_d = count_d + 21'd1;
    end
    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cv_q    <= 1'b0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      tab_q   <= 1'b0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cv_q    <= cv_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      tab_q   <= tab_d;
      mask_q  <= mask_d;
    end
  end

  assign pf.x_out              = x_q;
  assign pf.y_out              = y_q;
  assign pf.valid_out          = valid_q;
  assign pf.tabulate_out       = tab_q;
  assign pf.mask_out           = mask_q;
  assign pf.centroid_x_out     = cx_q;
  assign pf.centroid_y_out     = cy_q;
  assign pf.centroid_valid_out = cv_q;
  assign pf.frames_dropped_out = drop_q;
endmodule

// File: tb/tb_com_pixel_feeder.sv
// Directed frame scenarios with randomized pixel values and idle gaps, checked
// against expected sample lists and frame-level outcomes.
module tb_com_pixel_feeder;
  localparam int H  = 16;
  localparam int V  = 12;
  localparam int MP = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  com_pixel_feeder_if pf ();

  com_pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MP), .TIMEOUT_CYCLES(TO))
    dut (.clk_in(clk), .rst_in(rst), .pf(pf));

  int n_cmp = 0;
  int n_bad = 0;
  int tab_cnt = 0;
  bit both_seen = 1'b0;
  logic [7:0] lo, hi;
  logic [20:0] got_q[$];
  logic [20:0] exp_q[$];

  always @(negedge clk) if (!rst) begin
    if (pf.valid_out) got_q.push_back({pf.x_out, pf.y_out});
    if (pf.tabulate_out) tab_cnt++;
    if (pf.valid_out && pf.tabulate_out) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_bounds(input logic [7:0] l, input logic [7:0] h);
    lo = l; hi = h;
    pf.lower_bound_in = l;
    pf.upper_bound_in = h;
  endtask

  task automatic pix(input bit dv, input int h, input int v, input logic [7:0] ch);
    logic em;
    pf.data_valid_in = dv;
    pf.hcount_in     = 11'(h);
    pf.vcount_in     = 10'(v);
    pf.channel_in    = ch;
    em = dv && (lo <= ch) && (ch <= hi);
    @(posedge clk); #1;
    chk("mask", pf.mask_out, em);
    pf.data_valid_in = 1'b0;
  endtask

  // Region pixels get an in-bounds channel; everything else is out of bounds.
  task automatic frame(input int x0, input int y0, input int w, input int hh,
                       input bit expect_smp, input int stop_after);
    int n = 0;
    logic [7:0] ch;
    bit inreg;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) begin
        if (stop_after >= 0 && n == stop_after) return;
        if ($urandom_range(0, 7) == 0)
          pix(1'b0, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
              8'($urandom_range(0, 255)));
        inreg = (h >= x0) && (h < x0 + w) && (v >= y0) && (v < y0 + hh);
        if (lo > hi)        ch = 8'($urandom_range(0, 255));
        else if (inreg)     ch = 8'($urandom_range(int'(lo), int'(hi)));
        else if ($urandom_range(0, 1) == 1) ch = 8'($urandom_range(0, int'(lo) - 1));
        else                ch = 8'($urandom_range(int'(hi) + 1, 255));
        pix(1'b1, h, v, ch);
        if (inreg && expect_smp && lo <= hi) exp_q.push_back({11'(h), 10'(v)});
        n++;
      end
  endtask

  task automatic rand_bounds();
    set_bounds(8'($urandom_range(40, 100)), 8'($urandom_range(150, 210)));
  endtask

  task automatic check_samples();
    chk("n_samples", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("sample_xy", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_tab(input int target);
    for (int i = 0; i < 20 && tab_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk("tabulate_count", tab_cnt, target);
  endtask

  task automatic com_pulse(input int x, input int y);
    pf.com_x_in = 11'(x);
    pf.com_y_in = 10'(y);
    pf.com_valid_in = 1'b1;
    @(posedge clk); #1;
    pf.com_valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, pf.valid_out, 0);
    chk({tag, "_tab"}, pf.tabulate_out, 0);
    chk({tag, "_mask"}, pf.mask_out, 0);
    chk({tag, "_x"}, pf.x_out, 0);
    chk({tag, "_y"}, pf.y_out, 0);
    chk({tag, "_cx"}, pf.centroid_x_out, 0);
    chk({tag, "_cy"}, pf.centroid_y_out, 0);
    chk({tag, "_cv"}, pf.centroid_valid_out, 0);
    chk({tag, "_drop"}, pf.frames_dropped_out, 0);
  endtask

  int t;

  initial begin
    rst = 1'b1;
    pf.data_valid_in = 1'b0;
    pf.hcount_in = '0;
    pf.vcount_in = '0;
    pf.channel_in = '0;
    pf.com_x_in = '0;
    pf.com_y_in = '0;
    pf.com_valid_in = 1'b0;
    set_bounds(8'd100, 8'd150);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4x4 square -> 16 samples, one tabulate, accepted centroid
    rand_bounds();
    t = tab_cnt;
    frame(4, 4, 4, 4, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    com_pulse(5, 5);
    chk("sq_cx", pf.centroid_x_out, 5);
    chk("sq_cy", pf.centroid_y_out, 5);
    chk("sq_cv", pf.centroid_valid_out, 1);
    chk("sq_drop", pf.frames_dropped_out, 0);

    // empty frame: tabulate, no wait, result invalid, late com ignored
    set_bounds(8'd200, 8'd50);
    t = tab_cnt;
    frame(0, 0, 0, 0, 1'b1, -1);
    wait_tab(t + 1);
    chk("empty_cv", pf.centroid_valid_out, 0);
    com_pulse(9, 9);
    chk("empty_cx_hold", pf.centroid_x_out, 5);
    chk("empty_cy_hold", pf.centroid_y_out, 5);
    chk("empty_cv_after", pf.centroid_valid_out, 0);
    check_samples();

    // 8 pixels: centroid updated but below MIN_PIXELS
    rand_bounds();
    t = tab_cnt;
    frame(4, 4, 4, 2, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    com_pulse(3, 2);
    chk("few_cx", pf.centroid_x_out, 3);
    chk("few_cy", pf.centroid_y_out, 2);
    chk("few_cv", pf.centroid_valid_out, 0);

    // good frame, then one that times out
    rand_bounds();
    t = tab_cnt;
    frame(8, 2, 4, 4, 1'b1, -1);
    wait_tab(t + 1);
    com_pulse(7, 8);
    chk("good_cv", pf.centroid_valid_out, 1);
    t = tab_cnt;
    frame(1, 1, 5, 4, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    chk("pre_timeout_cv", pf.centroid_valid_out, 1);
    repeat (TO + 4) @(posedge clk);
    #1;
    chk("timeout_drop", pf.frames_dropped_out, 1);
    chk("timeout_cv", pf.centroid_valid_out, 0);

    // next frame arrives during WAIT_RESULT: skipped, then recovery
    rand_bounds();
    t = tab_cnt;
    frame(4, 4, 4, 4, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    frame(4, 4, 4, 4, 1'b0, -1);
    repeat (6) @(posedge clk);
    #1;
    chk("skip_no_tab", tab_cnt, t + 1);
    check_samples();
    chk("skip_drop", pf.frames_dropped_out, 3);
    frame(2, 3, 4, 4, 1'b1, -1);
    wait_tab(t + 2);
    check_samples();
    com_pulse(4, 5);
    chk("recover_cv", pf.centroid_valid_out, 1);
    chk("recover_cx", pf.centroid_x_out, 4);

    // truncated frame: restart clears the count, only one tabulate
    rand_bounds();
    t = tab_cnt;
    frame(4, 4, 4, 4, 1'b1, 100);
    frame(4, 8, 4, 2, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    com_pulse(6, 9);
    chk("trunc_cv", pf.centroid_valid_out, 0);
    chk("trunc_cy", pf.centroid_y_out, 9);
    chk("trunc_drop", pf.frames_dropped_out, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("trunc_one_tab", tab_cnt, t + 1);

    // reset mid-stream clears everything immediately
    rand_bounds();
    frame(4, 4, 4, 4, 1'b1, 90);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    t = tab_cnt;
    frame(6, 6, 4, 4, 1'b1, -1);
    wait_tab(t + 1);
    check_samples();
    com_pulse(7, 7);
    chk("post_rst_cv", pf.centroid_valid_out, 1);
    chk("post_rst_drop", pf.frames_dropped_out, 0);

    // repeated frame starts saturate the drop counter
    for (int i = 0; i < 300; i++) pix(1'b1, 0, 0, 8'($urandom_range(0, 255)));
    chk("drop_saturate", pf.frames_dropped_out, 255);
    got_q.delete();
    chk("valid_and_tab_exclusive", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
